// File: rtl/rp_trig_pkg.sv
// Shared definitions for the acquisition trigger controller: state codes,
// trigger source codes and the widths of the state and source buses.
package rp_trig_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned SRC_W   = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    typedef enum logic [SRC_W-1:0] {
        TRIG_NONE    = 4'd0,
        TRIG_MANUAL  = 4'd1,
        TRIG_ADC_A_P = 4'd2,
        TRIG_ADC_A_N = 4'd3,
        TRIG_ADC_B_P = 4'd4,
        TRIG_ADC_B_N = 4'd5,
        TRIG_EXT_P   = 4'd6,
        TRIG_EXT_N   = 4'd7,
        TRIG_ASG_P   = 4'd8,
        TRIG_ASG_N   = 4'd9
    } trig_src_e;

endpackage

// File: rtl/rp_trig_src_mux.sv
// Combinational trigger source select: reduces all event pulses to the single
// event chosen by trig_src_i. Unused codes never fire.
module rp_trig_src_mux
    import rp_trig_pkg::*;
(
    input  logic [SRC_W-1:0] trig_src_i,
    input  logic             manual_trig_i,
    input  logic [1:0]       adc_trig_p_i,
    input  logic [1:0]       adc_trig_n_i,
    input  logic             ext_trig_p_i,
    input  logic             ext_trig_n_i,
    input  logic             asg_trig_p_i,
    input  logic             asg_trig_n_i,
    output logic             trig_evt_c
);

    always_comb begin
        trig_evt_c = 1'b0;
        case (trig_src_e'(trig_src_i))
            TRIG_MANUAL:  trig_evt_c = manual_trig_i;
            TRIG_ADC_A_P: trig_evt_c = adc_trig_p_i[0];
            TRIG_ADC_A_N: trig_evt_c = adc_trig_n_i[0];
            TRIG_ADC_B_P: trig_evt_c = adc_trig_p_i[1];
            TRIG_ADC_B_N: trig_evt_c = adc_trig_n_i[1];
            TRIG_EXT_P:   trig_evt_c = ext_trig_p_i;
            TRIG_EXT_N:   trig_evt_c = ext_trig_n_i;
            TRIG_ASG_P:   trig_evt_c = asg_trig_p_i;
            TRIG_ASG_N:   trig_evt_c = asg_trig_n_i;
            default:      trig_evt_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/rp_trig_arm.sv
// Acquisition trigger controller: arm -> pre-trigger fill -> wait for trigger
// -> post-trigger capture -> done, driving the capture buffer write port.
module rp_trig_arm
    import rp_trig_pkg::*;
#(
    parameter int unsigned AW = 14,
    parameter int unsigned CW = 32
) (
    input  logic               adc_clk_i,
    input  logic               adc_rst_i,
    input  logic               sample_en_i,
    input  logic               arm_i,
    input  logic               abort_i,
    input  logic [SRC_W-1:0]   trig_src_i,
    input  logic               manual_trig_i,
    input  logic [1:0]         adc_trig_p_i,
    input  logic [1:0]         adc_trig_n_i,
    input  logic               ext_trig_p_i,
    input  logic               ext_trig_n_i,
    input  logic               asg_trig_p_i,
    input  logic               asg_trig_n_i,
    input  logic [CW-1:0]      pre_len_i,
    input  logic [CW-1:0]      post_len_i,
    output logic               wr_en_o,
    output logic [AW-1:0]      wr_ptr_o,
    output logic [AW-1:0]      trig_ptr_o,
    output logic               trig_o,
    output logic               done_o,
    output logic [STATE_W-1:0] state_o
);

    state_e          state_q, state_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   trig_ptr_q, trig_ptr_d;
    logic            trig_q, trig_d;
    logic            done_q, done_d;
    logic [CW-1:0]   pre_cnt_q, pre_cnt_d;
    logic [CW-1:0]   post_cnt_q, post_cnt_d;
    logic            trig_evt_c;

    rp_trig_src_mux u_src_mux (
        .trig_src_i    (trig_src_i),
        .manual_trig_i (manual_trig_i),
        .adc_trig_p_i  (adc_trig_p_i),
        .adc_trig_n_i  (adc_trig_n_i),
        .ext_trig_p_i  (ext_trig_p_i),
        .ext_trig_n_i  (ext_trig_n_i),
        .asg_trig_p_i  (asg_trig_p_i),
        .asg_trig_n_i  (asg_trig_n_i),
        .trig_evt_c    (trig_evt_c)
    );

    // Next-state and output logic; abort overrides everything else.
    always_comb begin
        state_d    = state_q;
        wr_en_d    = wr_en_q;
        trig_ptr_d = trig_ptr_q;
        trig_d     = 1'b0;
        pre_cnt_d  = pre_cnt_q;
        post_cnt_d = post_cnt_q;
        wr_ptr_d   = (wr_en_q && sample_en_i) ? wr_ptr_q + AW'(1) : wr_ptr_q;

        if (abort_i) begin
            state_d = ST_IDLE;
            wr_en_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm_i) begin
                        state_d   = (pre_len_i != '0) ? ST_PRE : ST_WAIT;
                        wr_en_d   = 1'b1;
                        pre_cnt_d = '0;
                    end
                end
                ST_PRE: begin
                    // Counters saturate rather than wrap.
                    if (sample_en_i && !(&pre_cnt_q)) begin
                        pre_cnt_d = pre_cnt_q + CW'(1);
                    end
                    if (pre_cnt_d >= pre_len_i) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (trig_evt_c) begin
                        state_d    = ST_POST;
                        trig_d     = 1'b1;
                        trig_ptr_d = wr_ptr_q;
                        post_cnt_d = '0;
                    end
                end
                ST_POST: begin
                    if (sample_en_i && !(&post_cnt_q)) begin
                        post_cnt_d = post_cnt_q + CW'(1);
                    end
                    if (post_cnt_d >= post_len_i) begin
                        state_d = ST_DONE;
                        wr_en_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    wr_en_d = 1'b0;
                end
            endcase
        end

        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            state_q    <= ST_IDLE;
            wr_en_q    <= 1'b0;
            wr_ptr_q   <= '0;
            trig_ptr_q <= '0;
            trig_q     <= 1'b0;
            done_q     <= 1'b0;
            pre_cnt_q  <= '0;
            post_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_en_q    <= wr_en_d;
            wr_ptr_q   <= wr_ptr_d;
            trig_ptr_q <= trig_ptr_d;
            trig_q     <= trig_d;
            done_q     <= done_d;
            pre_cnt_q  <= pre_cnt_d;
            post_cnt_q <= post_cnt_d;
        end
    end

    assign wr_en_o    = wr_en_q;
    assign wr_ptr_o   = wr_ptr_q;
    assign trig_ptr_o = trig_ptr_q;
    assign trig_o     = trig_q;
    assign done_o     = done_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_rp_trig_arm.sv
// Directed bench for rp_trig_arm: each task drives one scenario and checks
// registered outputs 1 ns after the rising edge against hand-computed values.
module tb_rp_trig_arm;

    localparam int unsigned AW = 14;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_en, arm, abort;
    logic [3:0]    src;
    logic          manual;
    logic [1:0]    adc_p, adc_n;
    logic          ext_p, ext_n, asg_p, asg_n;
    logic [CW-1:0] pre_len, post_len;
    logic          wr_en, trig, done;
    logic [AW-1:0] wr_ptr, trig_ptr;
    logic [2:0]    state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rp_trig_arm #(.AW(AW), .CW(CW)) dut (
        .adc_clk_i     (clk),
        .adc_rst_i     (rst),
        .sample_en_i   (sample_en),
        .arm_i         (arm),
        .abort_i       (abort),
        .trig_src_i    (src),
        .manual_trig_i (manual),
        .adc_trig_p_i  (adc_p),
        .adc_trig_n_i  (adc_n),
        .ext_trig_p_i  (ext_p),
        .ext_trig_n_i  (ext_n),
        .asg_trig_p_i  (asg_p),
        .asg_trig_n_i  (asg_n),
        .pre_len_i     (pre_len),
        .post_len_i    (post_len),
        .wr_en_o       (wr_en),
        .wr_ptr_o      (wr_ptr),
        .trig_ptr_o    (trig_ptr),
        .trig_o        (trig),
        .done_o        (done),
        .state_o       (state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sample_en = 1'b1; arm = 1'b1; abort = 1'b0; src = 4'd6;
        manual = 1'b0; adc_p = 2'b00; adc_n = 2'b00;
        ext_p = 1'b0; ext_n = 1'b0; asg_p = 1'b0; asg_n = 1'b0;
        pre_len = 4; post_len = 3;
        tick(); tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
        checks++; if (wr_ptr !== 14'd0) begin errors++; $display("FAIL reset_wr_ptr got %0d exp 0", wr_ptr); end
        checks++; if (trig_ptr !== 14'd0) begin errors++; $display("FAIL reset_trig_ptr got %0d exp 0", trig_ptr); end
        checks++; if ({trig, done} !== 2'b00) begin errors++; $display("FAIL reset_trig_done got %b exp 00", {trig, done}); end
        rst = 1'b0; arm = 1'b0;
        tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL idle_hold got %0d exp 0", state); end
    endtask

    // pre=4, post=3, ext rising; trigger after two idle WAIT cycles.
    task automatic test_basic();
        arm = 1'b1; tick(); arm = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (state !== 3'd1) begin errors++; $display("FAIL basic_pre i=%0d got %0d exp 1", i, state); end
            checks++; if (wr_ptr !== 14'(i)) begin errors++; $display("FAIL basic_pre_ptr i=%0d got %0d exp %0d", i, wr_ptr, i); end
            tick();
        end
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL basic_wait got %0d exp 2", state); end
        tick(); tick();
        checks++; if (wr_ptr !== 14'd6) begin errors++; $display("FAIL basic_wait_ptr got %0d exp 6", wr_ptr); end
        ext_p = 1'b1; tick(); ext_p = 1'b0;
        checks++; if ({trig, state} !== {1'b1, 3'd3}) begin errors++; $display("FAIL basic_trig got %b/%0d exp 1/3", trig, state); end
        checks++; if (trig_ptr !== 14'd6) begin errors++; $display("FAIL basic_trig_ptr got %0d exp 6", trig_ptr); end
        tick();
        checks++; if (trig !== 1'b0) begin errors++; $display("FAIL basic_trig_pulse got %b exp 0", trig); end
        tick(); tick();
        checks++; if ({state, done, wr_en} !== {3'd4, 1'b1, 1'b0}) begin errors++; $display("FAIL basic_done got %0d/%b/%b exp 4/1/0", state, done, wr_en); end
        checks++; if (wr_ptr !== 14'd10) begin errors++; $display("FAIL basic_final_ptr got %0d exp 10", wr_ptr); end
        tick();
        checks++; if ({wr_ptr, done} !== {14'd10, 1'b1}) begin errors++; $display("FAIL basic_done_hold got %0d/%b exp 10/1", wr_ptr, done); end
    endtask

    // Event seen only during PRE must not be remembered; then abort.
    task automatic test_pre_ignore();
        arm = 1'b1; tick(); arm = 1'b0;
        ext_p = 1'b1; tick(); ext_p = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if ({trig, state} !== {1'b0, 3'd2}) begin errors++; $display("FAIL preign_wait i=%0d got %b/%0d exp 0/2", i, trig, state); end
            tick();
        end
        abort = 1'b1; tick(); abort = 1'b0;
        checks++; if ({state, wr_en} !== {3'd0, 1'b0}) begin errors++; $display("FAIL preign_abort got %0d/%b exp 0/0", state, wr_en); end
        checks++; if (wr_ptr !== 14'd20) begin errors++; $display("FAIL preign_ptr got %0d exp 20", wr_ptr); end
    endtask

    // ASG falling at write pointer 2^AW-1; pointer then wraps to 0.
    task automatic test_wrap();
        src = 4'd9; pre_len = 16363; post_len = 2;
        arm = 1'b1; tick(); arm = 1'b0;
        repeat (16362) tick();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL wrap_pre_end got %0d exp 1", state); end
        asg_p = 1'b1; tick(); asg_p = 1'b0;
        checks++; if ({state, wr_ptr} !== {3'd2, 14'd16383}) begin errors++; $display("FAIL wrap_wait got %0d/%0d exp 2/16383", state, wr_ptr); end
        asg_n = 1'b1; tick(); asg_n = 1'b0;
        checks++; if ({trig, trig_ptr} !== {1'b1, 14'd16383}) begin errors++; $display("FAIL wrap_trig got %b/%0d exp 1/16383", trig, trig_ptr); end
        checks++; if (wr_ptr !== 14'd0) begin errors++; $display("FAIL wrap_ptr0 got %0d exp 0", wr_ptr); end
        tick(); tick();
        checks++; if ({state, done, wr_ptr} !== {3'd4, 1'b1, 14'd2}) begin errors++; $display("FAIL wrap_done got %0d/%b/%0d exp 4/1/2", state, done, wr_ptr); end
    endtask

    // Strobe every 4th cycle, pre=2: PRE spans two strobes (8 cycles).
    task automatic test_strobe();
        src = 4'd4; pre_len = 2; post_len = 1; sample_en = 1'b0;
        arm = 1'b1; tick(); arm = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sample_en = ((k % 4) == 3);
            tick();
            checks++; if (state !== ((k < 7) ? 3'd1 : 3'd2)) begin errors++; $display("FAIL strobe_state k=%0d got %0d", k, state); end
            checks++; if (wr_ptr !== 14'(2 + (k >= 3) + (k >= 7))) begin errors++; $display("FAIL strobe_ptr k=%0d got %0d", k, wr_ptr); end
        end
        sample_en = 1'b0;
        adc_p = 2'b01; tick();
        checks++; if ({trig, state} !== {1'b0, 3'd2}) begin errors++; $display("FAIL strobe_wrong_src got %b/%0d exp 0/2", trig, state); end
        adc_p = 2'b10; tick(); adc_p = 2'b00;
        checks++; if ({trig, state, trig_ptr} !== {1'b1, 3'd3, 14'd4}) begin errors++; $display("FAIL strobe_trig got %b/%0d/%0d exp 1/3/4", trig, state, trig_ptr); end
        tick();
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL strobe_post_hold got %0d exp 3", state); end
        sample_en = 1'b1; tick();
        checks++; if ({state, wr_ptr} !== {3'd4, 14'd5}) begin errors++; $display("FAIL strobe_done got %0d/%0d exp 4/5", state, wr_ptr); end
    endtask

    // Abort coincident with an accepted event wins.
    task automatic test_abort_trig();
        src = 4'd6; pre_len = 0;
        arm = 1'b1; tick(); arm = 1'b0;
        checks++; if ({state, wr_en, done} !== {3'd2, 1'b1, 1'b0}) begin errors++; $display("FAIL abort_armed got %0d/%b/%b exp 2/1/0", state, wr_en, done); end
        ext_p = 1'b1; abort = 1'b1; tick(); ext_p = 1'b0; abort = 1'b0;
        checks++; if ({state, trig, wr_en, done} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin errors++; $display("FAIL abort_win got %0d/%b/%b/%b exp 0/0/0/0", state, trig, wr_en, done); end
        checks++; if (wr_ptr !== 14'd6) begin errors++; $display("FAIL abort_ptr got %0d exp 6", wr_ptr); end
        arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
        checks++; if ({state, wr_en} !== {3'd0, 1'b0}) begin errors++; $display("FAIL abort_vs_arm got %0d/%b exp 0/0", state, wr_en); end
    endtask

    // Zero lengths with manual trigger, re-arm from DONE, arm ignored in WAIT.
    task automatic test_back_to_back();
        src = 4'd1; pre_len = 0; post_len = 0;
        arm = 1'b1; tick(); arm = 1'b0;
        ext_p = 1'b1; manual = 1'b1; tick(); ext_p = 1'b0; manual = 1'b0;
        checks++; if ({trig, state, trig_ptr, wr_ptr} !== {1'b1, 3'd3, 14'd6, 14'd7}) begin errors++; $display("FAIL b2b_trig got %b/%0d/%0d/%0d exp 1/3/6/7", trig, state, trig_ptr, wr_ptr); end
        tick();
        checks++; if ({state, done, wr_en, trig} !== {3'd4, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL b2b_done got %0d/%b/%b/%b exp 4/1/0/0", state, done, wr_en, trig); end
        arm = 1'b1; tick();
        checks++; if ({state, done, wr_en, wr_ptr} !== {3'd2, 1'b0, 1'b1, 14'd8}) begin errors++; $display("FAIL b2b_rearm got %0d/%b/%b/%0d exp 2/0/1/8", state, done, wr_en, wr_ptr); end
        tick(); arm = 1'b0;
        checks++; if ({state, wr_ptr} !== {3'd2, 14'd9}) begin errors++; $display("FAIL b2b_arm_ign got %0d/%0d exp 2/9", state, wr_ptr); end
        src = 4'd0; manual = 1'b1; tick();
        src = 4'd12; tick(); manual = 1'b0;
        checks++; if ({trig, state} !== {1'b0, 3'd2}) begin errors++; $display("FAIL b2b_src_none got %b/%0d exp 0/2", trig, state); end
    endtask

    // Synchronous reset mid-capture overrides arm.
    task automatic test_mid_reset();
        src = 4'd1; post_len = 5;
        manual = 1'b1; tick(); manual = 1'b0;
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL mreset_post got %0d exp 3", state); end
        rst = 1'b1; arm = 1'b1; tick(); rst = 1'b0; arm = 1'b0;
        checks++; if ({state, wr_en, wr_ptr, trig_ptr, trig, done} !== {3'd0, 1'b0, 14'd0, 14'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL mreset_vals got st=%0d we=%b wp=%0d tp=%0d t=%b d=%b exp all 0", state, wr_en, wr_ptr, trig_ptr, trig, done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pre_ignore();
        test_wrap();
        test_strobe();
        test_abort_trig();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
